ps2_keycode_decoder: RTL and testbench
======================================

PS2_KEYCODE_DECODER -- requirements
Module: ps2_keycode_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: Clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on PS2_CLK and PS2_DAT.
REQ-003 Clk  input  1  system clock (50 MHz); all logic on posedge Clk.
REQ-004 Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 PS2_CLK  input  1  keyboard clock, asynchronous to Clk.
REQ-006 PS2_DAT  input  1  keyboard data, asynchronous to Clk.
REQ-007 fireboy_keycode  output  8  HID usage of the Fireboy key currently held: 0x04 left (A), 0x07 right (D), 0x1A jump (W), 0x00 none.
REQ-008 icegirl_keycode  output  8  HID usage of the Icegirl key currently held: 0x50 left, 0x4F right, 0x52 jump (arrows), 0x00 none.
REQ-009 key_event  output  1  one-Clk pulse when either keycode output changes value.
REQ-010 frame_err  output  1  one-Clk pulse on a framing, stop-bit, timeout or (if enabled) parity error.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL pass through SYNC_STAGES synchronizers; a falling edge is old=1, new=0 of the synchronized clock.
REQ-012 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-013 IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0; with data=1, stay in IDLE and pulse frame_err.
REQ-014 DATA: on each falling edge, shift data into bit[count], LSB first; after the 8th bit, go to PARITY.
REQ-015 PARITY: capture the bit; go to STOP.
REQ-016 STOP: data=1 SHALL deliver the byte to the decoder one Clk later; data=0 SHALL discard the byte and pulse frame_err; both return to IDLE.
REQ-017 Idle counter clears on every falling edge. If it reaches TIMEOUT_CYCLES outside IDLE: return to IDLE, discard, pulse frame_err.
REQ-018 Scancode FSM states: NORM, EXT (after 0xE0), BRK (after 0xF0), EXTBRK (0xE0 then 0xF0).
REQ-019 Scancode transitions:
  - NORM: 0xE0 goes to EXT; 0xF0 goes to BRK.
  - EXT: 0xF0 goes to EXTBRK.
  - Any other byte is a make in NORM/EXT or a break in BRK/EXTBRK, then returns to NORM.
REQ-020 Mapped set-2 codes:
  - Non-extended: 0x1C=A, 0x23=D, 0x1D=W.
  - Extended: 0x6B=left, 0x74=right, 0x75=up.
  - All others, including typematic repeats, change nothing beyond the FSM.
REQ-021 Per player: a 3-bit held mask {jump,right,left} and a register holding the most recent make.
REQ-022 A make sets its held bit and the most-recent register. A break clears its held bit.
REQ-023 Keycode output value:
  - The most-recent key if still held.
  - Otherwise the highest-priority held key: jump > left > right.
  - Otherwise 0x00.
REQ-024 Keycode outputs SHALL be registered and update exactly 1 Clk after the byte completes the event; key_event pulses in the same cycle.
REQ-025 A repeated make of an already-held most-recent key SHALL not pulse key_event.
REQ-026 Fireboy and Icegirl state SHALL be fully independent; a byte affects at most one player.

Reset
REQ-027 Reset_n low SHALL asynchronously force:
  - both FSMs to IDLE/NORM;
  - counters, shift register and held masks to 0;
  - fireboy_keycode, icegirl_keycode, key_event and frame_err to 0.
REQ-028 Reset mid-frame SHALL discard the partial byte; the first post-reset falling edge is treated as a start bit.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN defined: odd parity over 8 data bits plus parity SHALL be checked at STOP; on mismatch the byte is discarded and frame_err pulses.
REQ-030 PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored.

Structure
REQ-031 Shared package keyboard_pkg SHALL hold:
  - HID usage constants 0x04/0x07/0x1A/0x50/0x4F/0x52;
  - set-2 scancode constants;
  - prefix constants 0xE0/0xF0;
  - rx and scancode state enums.
REQ-032 Sub-module ps2_rx SHALL contain the synchronizers, receiver FSM and timeout, with ports:
  - Clk, Reset_n, PS2_CLK, PS2_DAT in;
  - rx_byte[7:0], rx_valid, rx_err out.
REQ-033 The top level SHALL contain the scancode FSM, held masks and output registers.

Verification
REQ-034 Frame 0x1C (odd parity 0, stop 1) -> fireboy_keycode=0x04 one Clk after stop; key_event pulses once.
REQ-035 Hold A, then frames E0 74 -> icegirl_keycode=0x4F, fireboy_keycode stays 0x04; then E0 F0 74 -> icegirl_keycode=0x00.
REQ-036 Make A, make D, break D -> fireboy_keycode sequence 0x04, 0x07, 0x04; with W also held before break D -> 0x1A.
REQ-037 Byte 0x1C with parity bit 1 -> with PS2_PARITY_CHECK_EN: frame_err pulse and keycode unchanged; without: fireboy_keycode=0x04.
REQ-038 Four data bits then PS2_CLK held high for TIMEOUT_CYCLES -> frame_err pulse; the next full 0x1D frame -> fireboy_keycode=0x1A.
REQ-039 Reset_n low during the DATA bits of a frame -> outputs 0 immediately; the next clean 0x23 frame -> fireboy_keycode=0x07.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared constants, state encodings and per-player key helpers for the PS/2 keycode decoder.
package keyboard_pkg;

  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_LEFT  = 8'h50;
  localparam logic [7:0] HID_RIGHT = 8'h4F;
  localparam logic [7:0] HID_UP    = 8'h52;

  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_UP     = 8'h75;

  localparam logic [7:0] SC_PFX_EXT = 8'hE0;
  localparam logic [7:0] SC_PFX_BRK = 8'hF0;

  localparam logic [1:0] KEY_LEFT  = 2'd0;
  localparam logic [1:0] KEY_RIGHT = 2'd1;
  localparam logic [1:0] KEY_JUMP  = 2'd2;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {ST_NORM, ST_EXT, ST_BRK, ST_EXTBRK} sc_state_e;

  typedef struct packed {
    logic [2:0] held;    // {jump, right, left}
    logic [1:0] recent;  // key index of the most recent make
  } player_t;

  function automatic player_t apply_key(player_t p, logic [1:0] k, logic make);
    player_t    r;
    logic [2:0] sel;
    r   = p;
    sel = 3'(1) << k;
    if (make) begin
      r.held   = p.held | sel;
      r.recent = k;
    end else begin
      r.held = p.held & ~sel;
    end
    return r;
  endfunction

  // Most recent key wins while held; otherwise fixed priority jump > left > right.
  function automatic logic [7:0] resolve_key(player_t p, logic [7:0] u_left,
                                             logic [7:0] u_right, logic [7:0] u_jump);
    logic [2:0] sel;
    sel = 3'(1) << p.recent;
    if ((p.held & sel) != 3'b000) begin
      case (p.recent)
        KEY_LEFT:  return u_left;
        KEY_RIGHT: return u_right;
        default:   return u_jump;
      endcase
    end
    if (p.held[2]) return u_jump;
    if (p.held[0]) return u_left;
    if (p.held[1]) return u_right;
    return 8'h00;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronizers, frame FSM and inactivity timeout.
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx
  import keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic                   clk_old_q, clk_old_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;

  logic ps2_clk_s, ps2_dat_s, fall, parity_ok;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall      = clk_old_q & ~ps2_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign parity_ok     = 1'b1;
`endif

  always_comb begin
    clk_sync_d    = clk_sync_q;
    dat_sync_d    = dat_sync_q;
    clk_sync_d[0] = PS2_CLK;
    dat_sync_d[0] = PS2_DAT;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      clk_sync_d[i] = clk_sync_q[i-1];
      dat_sync_d[i] = dat_sync_q[i-1];
    end
    clk_old_d = ps2_clk_s;
  end

  // Frame FSM; the idle counter saturates and only matters outside RX_IDLE.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);

    if (fall) begin
      idle_cnt_d = '0;
      unique case (state_q)
        RX_IDLE: begin
          if (!ps2_dat_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d[bit_cnt_q] = ps2_dat_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = ps2_dat_s;
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (ps2_dat_s && parity_ok) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && idle_cnt_q == CNT_MAX) begin
      state_d  = RX_IDLE;
      rx_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      clk_old_q  <= 1'b0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      idle_cnt_q <= '0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_old_q  <= clk_old_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      idle_cnt_q <= idle_cnt_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 decoder for two players: scancode FSM, held-key masks and HID keycode outputs.
// Build option PS2_PARITY_CHECK_EN enables odd-parity checking in the receiver.
module ps2_keycode_decoder
  import keyboard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] fireboy_keycode,
  output logic [7:0] icegirl_keycode,
  output logic       key_event,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err)
  );

  sc_state_e  sc_q, sc_d;
  player_t    fb_q, fb_d, ig_q, ig_d;
  logic [7:0] fb_code_q, fb_code_d, ig_code_q, ig_code_d;
  logic       key_event_q, key_event_d, frame_err_q, frame_err_d;
  logic       key_act, key_ext, key_make;

  // Scancode FSM: prefixes only move state; any other byte is a make or break.
  always_comb begin
    sc_d     = sc_q;
    key_act  = 1'b0;
    key_ext  = 1'b0;
    key_make = 1'b0;
    if (rx_valid) begin
      sc_d = ST_NORM;
      unique case (sc_q)
        ST_NORM: begin
          if (rx_byte == SC_PFX_EXT)      sc_d = ST_EXT;
          else if (rx_byte == SC_PFX_BRK) sc_d = ST_BRK;
          else begin
            key_act  = 1'b1;
            key_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_PFX_BRK) sc_d = ST_EXTBRK;
          else begin
            key_act  = 1'b1;
            key_ext  = 1'b1;
            key_make = 1'b1;
          end
        end
        ST_BRK: key_act = 1'b1;
        ST_EXTBRK: begin
          key_act = 1'b1;
          key_ext = 1'b1;
        end
        default: sc_d = ST_NORM;
      endcase
    end
  end

  always_comb begin
    fb_d = fb_q;
    ig_d = ig_q;
    if (key_act) begin
      if (!key_ext) begin
        case (rx_byte)
          SC_A:    fb_d = apply_key(fb_q, KEY_LEFT, key_make);
          SC_D:    fb_d = apply_key(fb_q, KEY_RIGHT, key_make);
          SC_W:    fb_d = apply_key(fb_q, KEY_JUMP, key_make);
          default: ;
        endcase
      end else begin
        case (rx_byte)
          SC_LEFT:  ig_d = apply_key(ig_q, KEY_LEFT, key_make);
          SC_RIGHT: ig_d = apply_key(ig_q, KEY_RIGHT, key_make);
          SC_UP:    ig_d = apply_key(ig_q, KEY_JUMP, key_make);
          default:  ;
        endcase
      end
    end
    fb_code_d   = resolve_key(fb_d, HID_A, HID_D, HID_W);
    ig_code_d   = resolve_key(ig_d, HID_LEFT, HID_RIGHT, HID_UP);
    key_event_d = (fb_code_d != fb_code_q) || (ig_code_d != ig_code_q);
    frame_err_d = rx_err;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sc_q        <= ST_NORM;
      fb_q        <= '0;
      ig_q        <= '0;
      fb_code_q   <= 8'h00;
      ig_code_q   <= 8'h00;
      key_event_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      fb_q        <= fb_d;
      ig_q        <= ig_d;
      fb_code_q   <= fb_code_d;
      ig_code_q   <= ig_code_d;
      key_event_q <= key_event_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign fireboy_keycode = fb_code_q;
  assign icegirl_keycode = ig_code_q;
  assign key_event       = key_event_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Scoreboard bench for ps2_keycode_decoder: expected keycode events are queued per frame and
// popped on every key_event; frame_err pulses are counted against an expected total.
module tb_ps2_keycode_decoder;

  localparam int unsigned TO = 300;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] fireboy_keycode, icegirl_keycode;
  logic       key_event, frame_err;

  typedef struct packed {
    logic [7:0] fb;
    logic [7:0] ig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   err_seen = 0;
  int   err_exp  = 0;

  always #5 Clk = ~Clk;

  ps2_keycode_decoder #(
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (2)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .PS2_CLK        (PS2_CLK),
    .PS2_DAT        (PS2_DAT),
    .fireboy_keycode(fireboy_keycode),
    .icegirl_keycode(icegirl_keycode),
    .key_event      (key_event),
    .frame_err      (frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
  endtask

  task automatic ps2_bit(input logic v);
    PS2_DAT = v;
    wait_clk(10);
    PS2_CLK = 1'b0;
    wait_clk(20);
    PS2_CLK = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    logic [7:0] v;
    v = b;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit(~^v ^ bad_par);
    ps2_bit(stop);
    PS2_DAT = 1'b1;
    wait_clk(20);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic expect_ev(input logic [7:0] fb, input logic [7:0] ig);
    sb.push_back(exp_t'({fb, ig}));
  endtask

  task automatic settle(input string tag);
    wait_clk(5);
    #1;
    check_val({tag, "_pending"}, 32'(sb.size()), 32'd0);
    check_val({tag, "_errs"}, 32'(err_seen), 32'(err_exp));
  endtask

  // Event monitor: every key_event cycle must match the next queued expectation.
  always @(negedge Clk) begin
    if (Reset_n && key_event) begin
      if (sb.size() == 0) begin
        check_val("extra_key_event", 32'(key_event), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("fb_evt", 32'(fireboy_keycode), 32'(mon_e.fb));
        check_val("ig_evt", 32'(icegirl_keycode), 32'(mon_e.ig));
      end
    end
    if (Reset_n && frame_err) err_seen++;
  end

  initial begin
    wait_clk(4);
    #1;
    check_val("rst_fb", 32'(fireboy_keycode), 32'h00);
    check_val("rst_ig", 32'(icegirl_keycode), 32'h00);
    check_val("rst_evt", 32'(key_event), 32'd0);
    check_val("rst_err", 32'(frame_err), 32'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    wait_clk(5);

    expect_ev(8'h04, 8'h00); send(8'h1C);
    settle("make_a");
    check_val("make_a_fb", 32'(fireboy_keycode), 32'h04);

    expect_ev(8'h04, 8'h4F); send(8'hE0); send(8'h74);
    settle("ig_right");
    expect_ev(8'h04, 8'h00); send(8'hE0); send(8'hF0); send(8'h74);
    settle("ig_right_brk");
    check_val("ig_brk_fb", 32'(fireboy_keycode), 32'h04);

    send(8'h1C);
    settle("typematic");
    send(8'h15); send(8'hF0); send(8'h15); send(8'hE0); send(8'h1C);
    settle("unmapped");

    expect_ev(8'h07, 8'h00); send(8'h23);
    expect_ev(8'h04, 8'h00); send(8'hF0); send(8'h23);
    expect_ev(8'h1A, 8'h00); send(8'h1D);
    expect_ev(8'h07, 8'h00); send(8'h23);
    expect_ev(8'h1A, 8'h00); send(8'hF0); send(8'h23);
    expect_ev(8'h04, 8'h00); send(8'hF0); send(8'h1D);
    expect_ev(8'h07, 8'h00); send(8'h23);
    expect_ev(8'h1A, 8'h00); send(8'h1D);
    expect_ev(8'h04, 8'h00); send(8'hF0); send(8'h1D);
    expect_ev(8'h07, 8'h00); send(8'hF0); send(8'h1C);
    expect_ev(8'h00, 8'h00); send(8'hF0); send(8'h23);
    settle("fb_priority");

    expect_ev(8'h00, 8'h52); send(8'hE0); send(8'h75);
    expect_ev(8'h00, 8'h50); send(8'hE0); send(8'h6B);
    expect_ev(8'h00, 8'h52); send(8'hE0); send(8'hF0); send(8'h6B);
    expect_ev(8'h00, 8'h00); send(8'hE0); send(8'hF0); send(8'h75);
    settle("ig_priority");
    check_val("ig_idle", 32'(icegirl_keycode), 32'h00);

`ifdef PS2_PARITY_CHECK_EN
    err_exp++;
    send_frame(8'h1C, 1'b1, 1'b1);
    settle("bad_parity");
    check_val("bad_parity_fb", 32'(fireboy_keycode), 32'h00);
`else
    expect_ev(8'h04, 8'h00);
    send_frame(8'h1C, 1'b1, 1'b1);
    settle("bad_parity");
    expect_ev(8'h00, 8'h00); send(8'hF0); send(8'h1C);
    settle("bad_parity_clr");
`endif

    err_exp++;
    send_frame(8'h1D, 1'b0, 1'b0);
    settle("bad_stop");
    check_val("bad_stop_fb", 32'(fireboy_keycode), 32'h00);

    err_exp++;
    ps2_bit(1'b1);
    wait_clk(20);
    settle("no_start");

    err_exp++;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    wait_clk(TO + 50);
    settle("timeout");
    expect_ev(8'h1A, 8'h00); send(8'h1D);
    settle("after_timeout");
    expect_ev(8'h00, 8'h00); send(8'hF0); send(8'h1D);
    settle("after_timeout_brk");

    expect_ev(8'h07, 8'h00); send(8'h23);
    settle("pre_reset");
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    #3 Reset_n = 1'b0;
    #1;
    check_val("midrst_fb", 32'(fireboy_keycode), 32'h00);
    check_val("midrst_ig", 32'(icegirl_keycode), 32'h00);
    check_val("midrst_evt", 32'(key_event), 32'd0);
    check_val("midrst_err", 32'(frame_err), 32'd0);
    wait_clk(3);
    #1 Reset_n = 1'b1;
    wait_clk(5);
    expect_ev(8'h07, 8'h00); send(8'h23);
    settle("post_reset");
    check_val("post_reset_fb", 32'(fireboy_keycode), 32'h07);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
